pwm_duty_sequencer: RTL and testbench
=====================================

# pwm_duty_sequencer

Duty-cycle controller for a single PWM output channel. It owns the free-running period counter and compare, and accepts new duty targets through a valid/ready handshake. It ramps the active duty one code step at a time toward each target, applying every change only at a period boundary so no output pulse is ever truncated or stretched. It sits between switch/host control logic and the LED/motor pulse output.

## Interface

**Parameters**
- `CBITS`, default 18: period counter width. Period is 2^CBITS cycles.
- `DBITS`, default 4: duty code width. Requires `CBITS >= DBITS+2`.
- `HOLD_PERIODS`, default 4: number of PWM periods between successive ramp steps. Must be ≥1.

**Ports**
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, 1: new target duty offered.
- `req_duty`, in, DBITS: target duty code.
- `req_ready`, out, 1: high only in IDLE.
- `pwm_out`, out, 1: registered PWM output.
- `cur_duty`, out, DBITS: active duty code.
- `busy`, out, 1: high in RAMP or DONE.
- `done`, out, 1: single-cycle pulse when the target is reached.
- `period_end`, out, 1: combinational, high when `cnt == 2^CBITS-1`.

## Operation

- **Threshold:** `thr(d) = (2d+1) << (CBITS-DBITS-2)`, CBITS bits wide with no truncation.
  - Code 0 is never fully off.
  - The top code stays below 50% duty.
- **Counter and output:**
  - `cnt` increments every cycle and wraps from 2^CBITS-1 to 0.
  - `pwm_out <= (cnt < thr(cur_duty))`, evaluated on the pre-increment `cnt`.
- **Boundary:** a cycle with `period_end=1`. Any `cur_duty` change registers on that edge, so the new threshold first applies when `cnt==0`.
- **FSM states:** IDLE, RAMP, DONE.
  - **IDLE:** `req_ready=1`. On `req_valid`:
    - Latch `target`.
    - If `target==cur_duty`, go to DONE.
    - Otherwise load `hold = HOLD_PERIODS-1` and go to RAMP.
  - **RAMP:** act only on boundaries.
    - If `hold != 0`, decrement `hold`.
    - If `hold == 0`, step `cur_duty` by ±1 toward `target` and reload `hold = HOLD_PERIODS-1`.
    - If the stepped value equals `target`, go to DONE.
    - `req_valid` is ignored in this state (`req_ready=0`).
  - **DONE:** `done=1` for exactly one cycle, then IDLE.
- **Boundary in the accept cycle:** if the accept cycle is itself a boundary, that boundary is not counted. The first step occurs on the HOLD_PERIODS-th boundary strictly after accept.
- **Width rules:**
  - Steps never wrap; `cur_duty` stays within [min(start,target), max(start,target)].
  - All comparisons are unsigned.
- **Reset, including mid-ramp:**
  - `cnt=0`, `cur_duty=0`, `target=0`, `hold=0`, state IDLE.
  - `pwm_out=0`, `done=0`, `busy=0`, `req_ready=1` in the cycle after reset is sampled.
  - Any pending target is discarded.

## Timing

- **Accept latency:** `req_ready` falls the cycle after acceptance.
- **Equal target:** `done` is asserted on the cycle after acceptance and `req_ready` returns 1 the following cycle.
- **Ramp duration:** a ramp of N steps completes on the (N·HOLD_PERIODS)-th boundary after accept. `done` is high on the cycle after that boundary (when `cnt==0`), and `req_ready` returns 1 one cycle later.
- **pwm_out:**
  - Lags `cnt` by one cycle.
  - After reset, the first high is at cycle 1.
  - In a period with duty d, `pwm_out` is high exactly `thr(d)` consecutive cycles, covering `cnt` values 1..thr(d) after the edge.
- **busy:** equals `(state != IDLE)`, registered with the state.

## Structure

- **`pwm_pkg`:**
  - FSM state enum.
  - The `thr()` function, parameterized by CBITS/DBITS.
  - Parameter legality check (elaboration-time assertion on `CBITS >= DBITS+2` and `HOLD_PERIODS >= 1`).
- **`pwm_core` sub-module:** counter, `period_end`, compare and `pwm_out` register. It takes `cur_duty`.
- **Sequencer:** the FSM, hold counter and handshake stay in `pwm_duty_sequencer`.

## Test plan

All scenarios use CBITS=8, DBITS=4, HOLD_PERIODS=2. The period is 256 and `thr(d) = (2d+1)*4`.

- **Reset:** hold `rst` for 3 cycles, then release. Required: `pwm_out` high for exactly 4 cycles per period, `cur_duty=0`, `req_ready=1`, `busy=0`.
- **Up-ramp:** request duty 3 with `cnt=10`. Required:
  - `cur_duty` takes the values 1, 2, 3 at boundaries 2, 4 and 6.
  - Pulse widths are 4, 4, 12, 12, 20, 20, 28.
  - A single `done` pulse occurs on the cycle after the boundary that loads 3.
- **Down-ramp with mid-ramp request:** go from 15 to 13, with `req_valid` held high throughout RAMP. Required: the request is not accepted until IDLE, and the widths step 124 → 116 → 108.
- **Accept on a boundary:** `req_valid` coincides with `cnt=255`. Required: that boundary is not counted, and the first step occurs at the second later boundary.
- **Equal target:** request duty 0 from duty 0. Required: `done` on the next cycle, `busy` high for 1 cycle, `pwm_out` unchanged.
- **Reset mid-ramp:** assert `rst` for one cycle at `cnt=100` during a 0 → 9 ramp. Required: the next cycle shows `cnt=0`, `cur_duty=0`, IDLE, `pwm_out=0`, and no `done`.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_pkg                                                         |
// | Brief    : Shared state encoding, duty threshold and parameter checks.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Odd multiples of a quarter-step: code 0 is never dark, top code stays under 50%.
    function automatic logic [31:0] thr(input logic [31:0] d, input int cbits, input int dbits);
        return ((d << 1) + 32'd1) << (cbits - dbits - 2);
    endfunction

    function automatic bit params_ok(input int cbits, input int dbits, input int hold_periods);
        return (cbits >= dbits + 2) && (hold_periods >= 1) && (cbits <= 32);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_core                                                        |
// | Brief    : Free-running period counter, boundary flag and PWM compare.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CBITS = 18,
    parameter int DBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DBITS-1:0] cur_duty,
    output logic             pwm_out,
    output logic             period_end
);

    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] w_thr;
    logic             r_pwm;

    assign w_thr      = CBITS'(thr(32'(cur_duty), CBITS, DBITS));
    assign period_end = (r_cnt == {CBITS{1'b1}});
    assign pwm_out    = r_pwm;

    // Compare uses the pre-increment count, so the output lags the counter by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CBITS'(1);
            r_pwm <= (r_cnt < w_thr);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_duty_sequencer                                              |
// | Brief    : Ramps PWM duty toward requested targets at period boundaries.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int CBITS        = 18,
    parameter int DBITS        = 4,
    parameter int HOLD_PERIODS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [DBITS-1:0] req_duty,
    output logic             req_ready,
    output logic             pwm_out,
    output logic [DBITS-1:0] cur_duty,
    output logic             busy,
    output logic             done,
    output logic             period_end
);

    localparam int HBITS = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [HBITS-1:0] c_hold_reload = HBITS'(HOLD_PERIODS - 1);

    if (!params_ok(CBITS, DBITS, HOLD_PERIODS)) begin : g_param_check
        $error("pwm_duty_sequencer: illegal CBITS/DBITS/HOLD_PERIODS combination");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DBITS-1:0] r_duty;
    logic [DBITS-1:0] w_duty_nxt;
    logic [DBITS-1:0] r_target;
    logic [DBITS-1:0] w_target_nxt;
    logic [HBITS-1:0] r_hold;
    logic [HBITS-1:0] w_hold_nxt;
    logic [DBITS-1:0] w_step;

    pwm_core #(
        .CBITS (CBITS),
        .DBITS (DBITS)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .cur_duty   (r_duty),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_target <= '0;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_target <= w_target_nxt;
            r_hold   <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = r_target;
        w_hold_nxt   = r_hold;
        // Only used in RAMP, where target and duty always differ, so no wrap is possible.
        w_step       = (r_target > r_duty) ? (r_duty + DBITS'(1)) : (r_duty - DBITS'(1));

        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_target_nxt = req_duty;
                    if (req_duty == r_duty) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_hold_nxt  = c_hold_reload;
                        w_state_nxt = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (period_end) begin
                    if (r_hold != '0) begin
                        w_hold_nxt = r_hold - HBITS'(1);
                    end else begin
                        w_duty_nxt = w_step;
                        w_hold_nxt = c_hold_reload;
                        if (w_step == r_target) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign cur_duty  = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pwm_duty_sequencer                                           |
// | Brief    : Self-checking bench against a behavioural duty-ramp model.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pwm_duty_sequencer;

    localparam int CBITS = 8;
    localparam int DBITS = 4;
    localparam int HOLD  = 2;
    localparam int PER   = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_duty;
    logic       req_ready;
    logic       pwm_out;
    logic [3:0] cur_duty;
    logic       busy;
    logic       done;
    logic       period_end;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm_duty_sequencer #(
        .CBITS        (CBITS),
        .DBITS        (DBITS),
        .HOLD_PERIODS (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_duty   (req_duty),
        .req_ready  (req_ready),
        .pwm_out    (pwm_out),
        .cur_duty   (cur_duty),
        .busy       (busy),
        .done       (done),
        .period_end (period_end)
    );

    // Reference model: phase 0 idle, 1 ramping, 2 target reached.
    int m_cnt    = 0;
    int m_duty   = 0;
    int m_target = 0;
    int m_phase  = 0;
    int m_bcount = 0;
    bit m_pwm    = 1'b0;
    bit m_pe;

    function automatic int thr_m(input int d);
        return (2 * d + 1) * 4;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0; m_duty = 0; m_target = 0; m_phase = 0; m_bcount = 0; m_pwm = 1'b0;
        end else begin
            m_pe  = (m_cnt == PER - 1);
            m_pwm = (m_cnt < thr_m(m_duty));
            m_cnt = (m_cnt + 1) % PER;
            case (m_phase)
                0: if (req_valid) begin
                    m_target = int'(req_duty);
                    if (m_target == m_duty) m_phase = 2;
                    else begin m_phase = 1; m_bcount = 0; end
                end
                1: if (m_pe) begin
                    m_bcount++;
                    if (m_bcount % HOLD == 0) begin
                        m_duty = (m_target > m_duty) ? m_duty + 1 : m_duty - 1;
                        if (m_duty == m_target) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    function automatic logic [8:0] expv();
        logic [3:0] d;
        d = m_duty[3:0];
        return {m_pwm, d, m_phase == 0, m_phase != 0, m_phase == 2, m_cnt == PER - 1};
    endfunction

    function automatic logic [8:0] obsv();
        return {pwm_out, cur_duty, req_ready, busy, done, period_end};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cnt(input int c);
        for (int k = 0; k < PER && m_cnt != c; k++) tick();
    endtask

    task automatic test_reset();
        int highs = 0;
        rst = 1'b1; req_valid = 1'b0; req_duty = 4'd0;
        repeat (3) tick();
        vectors++;
        if ({pwm_out, cur_duty, req_ready, busy, done} !== 8'b0_0000_100) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 00000100", {pwm_out, cur_duty, req_ready, busy, done});
        end
        rst = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            tick();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL reset_run cycle %0d: got %b expected %b", i, obsv(), expv());
            end
            if (i == 0) begin
                vectors++;
                if (pwm_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_first_high: got %b expected 1", pwm_out);
                end
            end
            highs += int'(pwm_out);
        end
        vectors++;
        if (highs != 8) begin
            miscompares++;
            $display("FAIL reset_width: got %0d high cycles over two periods, expected 8", highs);
        end
    endtask

    task automatic test_equal();
        req_valid = 1'b1; req_duty = 4'd0;
        tick();
        req_valid = 1'b0;
        vectors++;
        if ({done, busy, req_ready, cur_duty} !== 7'b110_0000 || obsv() !== expv()) begin
            miscompares++;
            $display("FAIL equal_done: got %b/%b expected done=1 busy=1 ready=0 duty=0 (%b)", {done, busy, req_ready}, obsv(), expv());
        end
        tick();
        vectors++;
        if ({done, busy, req_ready} !== 3'b001 || obsv() !== expv()) begin
            miscompares++;
            $display("FAIL equal_idle: got %b/%b expected done=0 busy=0 ready=1 (%b)", {done, busy, req_ready}, obsv(), expv());
        end
    endtask

    task automatic test_up_ramp();
        int widths [7];
        int exp_w  [7] = '{4, 4, 12, 12, 20, 20, 28};
        int done_cnt = 0;
        int done_at  = -1;
        bit fired = 1'b0;
        foreach (widths[p]) widths[p] = 0;
        wait_cnt(0);
        for (int i = 0; i < 7 * PER; i++) begin
            fired = (i < PER) && (m_cnt == 10);
            req_valid = fired; req_duty = 4'd3;
            tick();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL up_ramp cycle %0d: got %b expected %b", i, obsv(), expv());
            end
            if (fired) begin
                vectors++;
                if (req_ready !== 1'b0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL up_accept: got ready=%b busy=%b expected ready=0 busy=1", req_ready, busy);
                end
            end
            widths[i / PER] += int'(pwm_out);
            if (done === 1'b1) begin done_cnt++; done_at = i; end
        end
        req_valid = 1'b0;
        for (int p = 0; p < 7; p++) begin
            vectors++;
            if (widths[p] != exp_w[p]) begin
                miscompares++;
                $display("FAIL up_width period %0d: got %0d expected %0d", p, widths[p], exp_w[p]);
            end
        end
        vectors++;
        if (done_cnt != 1 || done_at != 6 * PER - 1 || cur_duty !== 4'd3) begin
            miscompares++;
            $display("FAIL up_done: got %0d pulses at %0d duty %0d, expected 1 at %0d duty 3", done_cnt, done_at, cur_duty, 6 * PER - 1);
        end
    endtask

    task automatic test_down_ramp();
        int widths [5];
        int exp_w  [5] = '{124, 124, 116, 116, 108};
        int done_cnt = 0;
        bit found = 1'b0;
        bit holding = 1'b0;
        foreach (widths[p]) widths[p] = 0;
        req_valid = 1'b1; req_duty = 4'd15;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 12 * HOLD * PER + 600 && !found; i++) begin
            tick();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL to_top cycle %0d: got %b expected %b", i, obsv(), expv());
            end
            found = (done === 1'b1);
        end
        vectors++;
        if (!found || cur_duty !== 4'd15) begin
            miscompares++;
            $display("FAIL to_top_timeout: got duty %0d done_seen=%0d expected duty 15 done_seen=1", cur_duty, found);
        end
        wait_cnt(0);
        for (int i = 0; i < 5 * PER; i++) begin
            if (i == 50) holding = 1'b1;
            req_valid = holding;
            req_duty  = (i == 50) ? 4'd13 : 4'($urandom_range(0, 15));
            tick();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL down_ramp cycle %0d: got %b expected %b", i, obsv(), expv());
            end
            if (done === 1'b1) begin done_cnt++; holding = 1'b0; end
            widths[i / PER] += int'(pwm_out);
        end
        req_valid = 1'b0;
        for (int p = 0; p < 5; p++) begin
            vectors++;
            if (widths[p] != exp_w[p]) begin
                miscompares++;
                $display("FAIL down_width period %0d: got %0d expected %0d", p, widths[p], exp_w[p]);
            end
        end
        tick();
        vectors++;
        if (done_cnt != 1 || cur_duty !== 4'd13 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL down_final: got pulses=%0d duty=%0d ready=%b expected 1/13/1", done_cnt, cur_duty, req_ready);
        end
    endtask

    task automatic test_accept_boundary();
        int step_at = -1;
        wait_cnt(PER - 1);
        req_valid = 1'b1; req_duty = 4'd14;
        for (int k = 1; k <= 700 && step_at < 0; k++) begin
            tick();
            req_valid = 1'b0;
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL boundary cycle %0d: got %b expected %b", k, obsv(), expv());
            end
            if (cur_duty === 4'd14) step_at = k;
        end
        vectors++;
        if (step_at != 2 * PER + 1 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL boundary_step: got step at %0d done=%b expected step at %0d done=1", step_at, done, 2 * PER + 1);
        end
        tick();
    endtask

    task automatic test_reset_mid_ramp();
        int pe_at = -1;
        int done_seen = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 1'b1; req_duty = 4'd9;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3 * PER; i++) begin
            tick();
            vectors++;
            if (obsv() !== expv()) begin
                miscompares++;
                $display("FAIL mid_ramp cycle %0d: got %b expected %b", i, obsv(), expv());
            end
        end
        wait_cnt(100);
        vectors++;
        if (busy !== 1'b1 || cur_duty === 4'd0) begin
            miscompares++;
            $display("FAIL mid_ramp_pre: got busy=%b duty=%0d expected busy=1 duty>0", busy, cur_duty);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({pwm_out, cur_duty, req_ready, busy, done, period_end} !== 9'b0_0000_1000) begin
            miscompares++;
            $display("FAIL mid_reset_state: got %b expected 000001000", obsv());
        end
        for (int k = 1; k <= 300 && pe_at < 0; k++) begin
            tick();
            done_seen += int'(done === 1'b1);
            if (period_end === 1'b1) pe_at = k;
        end
        vectors++;
        if (pe_at != PER - 1 || done_seen != 0) begin
            miscompares++;
            $display("FAIL mid_reset_cnt: got boundary after %0d cycles done=%0d expected %0d and 0", pe_at, done_seen, PER - 1);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int  tgt;
            bit  found = 1'b0;
            int  gap = int'($urandom_range(0, 300));
            for (int i = 0; i < gap; i++) begin
                tick();
                vectors++;
                if (obsv() !== expv()) begin
                    miscompares++;
                    $display("FAIL rand_idle round %0d: got %b expected %b", r, obsv(), expv());
                end
            end
            tgt = m_duty + int'($urandom_range(0, 6)) - 3;
            if (tgt < 0) tgt = 0;
            if (tgt > 15) tgt = 15;
            req_valid = 1'b1; req_duty = 4'(tgt);
            for (int i = 0; i < 4 * HOLD * PER + 600 && !found; i++) begin
                tick();
                vectors++;
                if (obsv() !== expv()) begin
                    miscompares++;
                    $display("FAIL rand_ramp round %0d cycle %0d: got %b expected %b", r, i, obsv(), expv());
                end
                found = (done === 1'b1);
                req_valid = (m_phase == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                req_duty  = 4'($urandom_range(0, 15));
            end
            req_valid = 1'b0;
            vectors++;
            if (!found || cur_duty !== 4'(tgt)) begin
                miscompares++;
                $display("FAIL rand_target round %0d: got duty %0d done_seen=%0d expected %0d and 1", r, cur_duty, found, tgt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_up_ramp();
        test_down_ramp();
        test_accept_boundary();
        test_reset_mid_ramp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
